// File: rtl/soc_riscv_termination_monitor.sv
// Watches the per-core retirement trace, records sticky termination and exit codes, counts
// retirements, and ends the run as DONE, TIMEOUT or HANG until the next reset.
module soc_riscv_termination_monitor #(
  parameter int unsigned     NUM_CORES      = 1,
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] TERM_INSN      = XLEN'(32'h00100013),
  parameter int unsigned     CNT_W          = 32,
  parameter int unsigned     TIMEOUT_CYCLES = 0,
  parameter int unsigned     STALL_LIMIT    = 4096
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_CORES-1:0]      trace_valid_i,
  input  logic [NUM_CORES*XLEN-1:0] trace_insn_i,
  input  logic [NUM_CORES*XLEN-1:0] trace_r3_i,
  input  logic                      cpu_stall_i,
  output logic [NUM_CORES-1:0]      termination_o,
  output logic [NUM_CORES*XLEN-1:0] exit_code_o,
  output logic [NUM_CORES*CNT_W-1:0] retired_o,
  output logic                      done_o,
  output logic                      timeout_o,
  output logic                      hang_o,
  output logic                      fail_o,
  output logic [1:0]                state_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DONE    = 2'd1,
    TIMEOUT = 2'd2,
    HANG    = 2'd3
  } state_e;

  localparam bit              TO_EN      = (TIMEOUT_CYCLES != 0);
  localparam bit              STALL_EN   = (STALL_LIMIT != 0);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_LIMIT - 1);

  logic [NUM_CORES-1:0][XLEN-1:0]  insn;
  logic [NUM_CORES-1:0][XLEN-1:0]  r3;

  state_e                          state_q;
  logic [NUM_CORES-1:0]            term_q, term_d;
  logic [NUM_CORES-1:0][XLEN-1:0]  exit_q, exit_d;
  logic [NUM_CORES-1:0][CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0]                cyc_q, cyc_d;
  logic [CNT_W-1:0]                idle_q, idle_d;
  logic                            done_q, timeout_q, hang_q, fail_q;

  logic [NUM_CORES-1:0]            active;
  logic [NUM_CORES-1:0]            hit;
  logic                            complete;
  logic                            idle_clr;
  logic                            to_hit;
  logic                            hang_hit;
  logic                            exit_nz;

  assign insn = trace_insn_i;
  assign r3   = trace_r3_i;

  // A core that has already terminated is invisible: no count, no capture, no progress.
  always_comb begin
    active  = trace_valid_i & ~term_q;
    hit     = '0;
    exit_d  = exit_q;
    ret_d   = ret_q;
    exit_nz = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      hit[i] = active[i] && (insn[i] == TERM_INSN);
      if (hit[i]) begin
        exit_d[i] = r3[i];
      end
      if (active[i] && (ret_q[i] != '1)) begin
        ret_d[i] = ret_q[i] + CNT_W'(1);
      end
      exit_nz = exit_nz | (exit_d[i] != '0);
    end
    term_d   = term_q | hit;
    complete = &term_d;

    cyc_d    = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
    idle_clr = cpu_stall_i | (|active);
    if (idle_clr) begin
      idle_d = '0;
    end else begin
      idle_d = (idle_q == '1) ? idle_q : idle_q + CNT_W'(1);
    end

    to_hit   = TO_EN && (cyc_q == TO_LAST);
    hang_hit = STALL_EN && !idle_clr && (idle_q == STALL_LAST);
  end

  // Only RUN updates anything; the three exit states hold every register until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      term_q    <= '0;
      exit_q    <= '0;
      ret_q     <= '0;
      cyc_q     <= '0;
      idle_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      hang_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else if (state_q == RUN) begin
      term_q <= term_d;
      exit_q <= exit_d;
      ret_q  <= ret_d;
      cyc_q  <= cyc_d;
      idle_q <= idle_d;
      if (complete) begin
        state_q <= DONE;
        done_q  <= 1'b1;
        fail_q  <= exit_nz;
      end else if (to_hit) begin
        state_q   <= TIMEOUT;
        timeout_q <= 1'b1;
        fail_q    <= 1'b1;
      end else if (hang_hit) begin
        state_q <= HANG;
        hang_q  <= 1'b1;
        fail_q  <= 1'b1;
      end
    end
  end

  assign termination_o = term_q;
  assign exit_code_o   = exit_q;
  assign retired_o     = ret_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;
  assign hang_o        = hang_q;
  assign fail_o        = fail_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_soc_riscv_termination_monitor.sv
// Directed bench: single-core instance (CNT_W=4, STALL_LIMIT=16) and four-core instance (TIMEOUT_CYCLES=100).
module tb_soc_riscv_termination_monitor;

  localparam logic [31:0] TERM = 32'h00100013;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst1, st1;
  logic [0:0]  tv1;
  logic [31:0] ti1, tr1;
  logic [0:0]  term1;
  logic [31:0] ex1;
  logic [3:0]  ret1;
  logic        done1, to1, hang1, fail1;
  logic [1:0]  state1;

  logic         rst4, st4;
  logic [3:0]   tv4;
  logic [127:0] ti4, tr4;
  logic [3:0]   term4;
  logic [127:0] ex4, ret4;
  logic         done4, to4, hang4, fail4;
  logic [1:0]   state4;

  soc_riscv_termination_monitor #(
    .NUM_CORES(1), .XLEN(32), .CNT_W(4), .TIMEOUT_CYCLES(0), .STALL_LIMIT(16)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .trace_valid_i(tv1), .trace_insn_i(ti1), .trace_r3_i(tr1),
    .cpu_stall_i(st1), .termination_o(term1), .exit_code_o(ex1), .retired_o(ret1),
    .done_o(done1), .timeout_o(to1), .hang_o(hang1), .fail_o(fail1), .state_o(state1)
  );

  soc_riscv_termination_monitor #(
    .NUM_CORES(4), .XLEN(32), .CNT_W(32), .TIMEOUT_CYCLES(100), .STALL_LIMIT(4096)
  ) u_dut4 (
    .clk_i(clk), .rst_i(rst4), .trace_valid_i(tv4), .trace_insn_i(ti4), .trace_r3_i(tr4),
    .cpu_stall_i(st4), .termination_o(term4), .exit_code_o(ex4), .retired_o(ret4),
    .done_o(done4), .timeout_o(to4), .hang_o(hang4), .fail_o(fail4), .state_o(state4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_both();
    rst1 = 1'b1; tv1 = '0; ti1 = '0; tr1 = '0; st1 = 1'b0;
    rst4 = 1'b1; tv4 = '0; ti4 = '0; tr4 = '0; st4 = 1'b0;
    tick();
    tick();
    rst1 = 1'b0;
    rst4 = 1'b0;
  endtask

  task automatic test_reset();
    reset_both();
    checks++; if (state1 !== 2'd0) begin errors++; $display("FAIL reset_state1: got %0d expected 0", state1); end
    checks++; if ({term1, ex1, ret1, done1, to1, hang1, fail1} !== '0) begin errors++; $display("FAIL reset_outs1: got term=%0h ex=%0h ret=%0h d=%0b t=%0b h=%0b f=%0b expected all 0", term1, ex1, ret1, done1, to1, hang1, fail1); end
    checks++; if (state4 !== 2'd0) begin errors++; $display("FAIL reset_state4: got %0d expected 0", state4); end
    checks++; if ({term4, ex4, ret4, done4, to4, hang4, fail4} !== '0) begin errors++; $display("FAIL reset_outs4: got term=%0h d=%0b t=%0b h=%0b f=%0b expected all 0", term4, done4, to4, hang4, fail4); end
  endtask

  task automatic test_single_core_done();
    reset_both();
    tv1 = 1'b1; ti1 = NOP; tr1 = 32'd9;
    for (int i = 0; i < 10; i++) tick();
    ti1 = TERM; tr1 = 32'd0;
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL sc_done_early: got %0b expected 0", done1); end
    tick();
    ti1 = NOP;
    checks++; if (ret1 !== 4'd11) begin errors++; $display("FAIL sc_retired: got %0d expected 11", ret1); end
    checks++; if (term1 !== 1'b1) begin errors++; $display("FAIL sc_term: got %0b expected 1", term1); end
    checks++; if (done1 !== 1'b1 || state1 !== 2'd1) begin errors++; $display("FAIL sc_done: got done=%0b state=%0d expected 1/1", done1, state1); end
    checks++; if (fail1 !== 1'b0) begin errors++; $display("FAIL sc_fail: got %0b expected 0", fail1); end
    for (int i = 0; i < 3; i++) tick();
    tv1 = 1'b0;
    checks++; if (ret1 !== 4'd11 || state1 !== 2'd1) begin errors++; $display("FAIL sc_freeze: got ret=%0d state=%0d expected 11/1", ret1, state1); end
  endtask

  task automatic test_multi_core();
    reset_both();
    tv4 = 4'b1111;
    ti4 = {NOP, TERM, NOP, TERM};
    tr4 = {32'd0, 32'd5, 32'd0, 32'd0};
    tick();
    checks++; if (term4 !== 4'b0101) begin errors++; $display("FAIL mc_term_first: got %b expected 0101", term4); end
    checks++; if (ex4[64 +: 32] !== 32'd5) begin errors++; $display("FAIL mc_exit2: got %0d expected 5", ex4[64 +: 32]); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL mc_done_early: got %0b expected 0", done4); end
    ti4 = {NOP, NOP, NOP, NOP};
    tick();
    tick();
    ti4 = {TERM, NOP, TERM, NOP};
    tr4 = '0;
    checks++; if (done4 !== 1'b0 || state4 !== 2'd0) begin errors++; $display("FAIL mc_run: got done=%0b state=%0d expected 0/0", done4, state4); end
    tick();
    tv4 = '0;
    checks++; if (done4 !== 1'b1 || term4 !== 4'b1111) begin errors++; $display("FAIL mc_done: got done=%0b term=%b expected 1/1111", done4, term4); end
    checks++; if (fail4 !== 1'b1 || state4 !== 2'd1) begin errors++; $display("FAIL mc_fail: got fail=%0b state=%0d expected 1/1", fail4, state4); end
    checks++; if (ret4[32 +: 32] !== 32'd4 || ret4[0 +: 32] !== 32'd1) begin errors++; $display("FAIL mc_retired: got r1=%0d r0=%0d expected 4/1", ret4[32 +: 32], ret4[0 +: 32]); end
    checks++; if (ex4[64 +: 32] !== 32'd5) begin errors++; $display("FAIL mc_exit2_final: got %0d expected 5", ex4[64 +: 32]); end
  endtask

  task automatic test_sticky();
    reset_both();
    tv4 = 4'b0011;
    ti4 = {NOP, NOP, NOP, TERM};
    tr4 = '0;
    tick();
    checks++; if (term4 !== 4'b0001) begin errors++; $display("FAIL st_term: got %b expected 0001", term4); end
    tr4[31:0] = 32'd7;
    tick();
    ti4[31:0] = NOP;
    for (int i = 0; i < 3; i++) tick();
    tv4 = '0;
    checks++; if (ex4[0 +: 32] !== 32'd0) begin errors++; $display("FAIL st_exit0: got %0d expected 0", ex4[0 +: 32]); end
    checks++; if (ret4[0 +: 32] !== 32'd1) begin errors++; $display("FAIL st_ret0: got %0d expected 1", ret4[0 +: 32]); end
    checks++; if (ret4[32 +: 32] !== 32'd5) begin errors++; $display("FAIL st_ret1: got %0d expected 5", ret4[32 +: 32]); end
    checks++; if (state4 !== 2'd0 || done4 !== 1'b0) begin errors++; $display("FAIL st_state: got state=%0d done=%0b expected 0/0", state4, done4); end
  endtask

  task automatic test_timeout();
    reset_both();
    tv4 = 4'b0001;
    ti4 = {NOP, NOP, NOP, NOP};
    for (int i = 0; i < 99; i++) tick();
    checks++; if (to4 !== 1'b0 || state4 !== 2'd0) begin errors++; $display("FAIL to_early: got to=%0b state=%0d expected 0/0", to4, state4); end
    tick();
    checks++; if (to4 !== 1'b1 || state4 !== 2'd2) begin errors++; $display("FAIL to_hit: got to=%0b state=%0d expected 1/2", to4, state4); end
    checks++; if (fail4 !== 1'b1 || done4 !== 1'b0 || hang4 !== 1'b0) begin errors++; $display("FAIL to_flags: got f=%0b d=%0b h=%0b expected 1/0/0", fail4, done4, hang4); end
    checks++; if (ret4[0 +: 32] !== 32'd100) begin errors++; $display("FAIL to_ret: got %0d expected 100", ret4[0 +: 32]); end
    for (int i = 0; i < 5; i++) tick();
    tv4 = '0;
    checks++; if (ret4[0 +: 32] !== 32'd100 || state4 !== 2'd2) begin errors++; $display("FAIL to_freeze: got ret=%0d state=%0d expected 100/2", ret4[0 +: 32], state4); end
  endtask

  task automatic test_hang();
    logic seen;
    reset_both();
    for (int i = 0; i < 15; i++) tick();
    checks++; if (hang1 !== 1'b0 || state1 !== 2'd0) begin errors++; $display("FAIL hang_early: got hang=%0b state=%0d expected 0/0", hang1, state1); end
    tick();
    checks++; if (hang1 !== 1'b1 || state1 !== 2'd3) begin errors++; $display("FAIL hang_hit: got hang=%0b state=%0d expected 1/3", hang1, state1); end
    checks++; if (fail1 !== 1'b1) begin errors++; $display("FAIL hang_fail: got %0b expected 1", fail1); end

    reset_both();
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      st1 = (c % 10 == 9);
      tick();
      if (hang1 !== 1'b0) seen = 1'b1;
    end
    st1 = 1'b0;
    checks++; if (seen !== 1'b0 || state1 !== 2'd0) begin errors++; $display("FAIL stall_nohang: got seen=%0b state=%0d expected 0/0", seen, state1); end
  endtask

  task automatic test_saturate_and_reset();
    reset_both();
    tv1 = 1'b1; ti1 = NOP;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (ret1 !== 4'd15) begin errors++; $display("FAIL sat_ret: got %0d expected 15", ret1); end
    checks++; if (state1 !== 2'd0) begin errors++; $display("FAIL sat_state: got %0d expected 0", state1); end
    rst1 = 1'b1;
    tick();
    checks++; if ({term1, ex1, ret1, done1, to1, hang1, fail1, state1} !== '0) begin errors++; $display("FAIL midrst: got ret=%0d state=%0d term=%0b expected all 0", ret1, state1, term1); end
    rst1 = 1'b0;
    tick();
    tv1 = 1'b0;
    checks++; if (ret1 !== 4'd1) begin errors++; $display("FAIL post_rst_count: got %0d expected 1", ret1); end
  endtask

  initial begin
    test_reset();
    test_single_core_done();
    test_multi_core();
    test_sticky();
    test_timeout();
    test_hang();
    test_saturate_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_riscv_termination_monitor.md
Name: soc_riscv_termination_monitor

Overview:
Parametrised simulation and debug monitor that watches the per-core retirement trace of a compute tile and decides when the run has finished. Generalises the single-core, combinational termination check to N cores. Adds sticky per-core exit codes, saturating retired-instruction counters, a global timeout and a no-progress (hang) detector, all driven by one state machine. Sits beside the tile in the system testbench; its outputs stop the simulation and report pass or fail.

Parameters:
NUM_CORES, 1, number of monitored cores (1..64)
XLEN, 32, instruction/register width
TERM_INSN, 32'h00100013, retired instruction word that marks termination (addi x0,x0,1)
CNT_W, 32, width of the per-core retired counters and the internal cycle/idle counters
TIMEOUT_CYCLES, 0, cycles in RUN before TIMEOUT; 0 disables
STALL_LIMIT, 4096, consecutive cycles without progress before HANG; 0 disables

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
trace_valid  in  NUM_CORES  core i retired an instruction this cycle
trace_insn  in  NUM_CORES*XLEN  retired instruction word, core i at [i*XLEN +: XLEN]
trace_r3  in  NUM_CORES*XLEN  value of x3 at retirement, same packing
cpu_stall  in  1  global stall; counts as progress for the hang detector
termination  out  NUM_CORES  sticky, core i has executed TERM_INSN
exit_code  out  NUM_CORES*XLEN  trace_r3 captured at termination of core i
retired  out  NUM_CORES*CNT_W  saturating retired-instruction count per core
done  out  1  state==DONE
timeout  out  1  state==TIMEOUT
hang  out  1  state==HANG
fail  out  1  timeout | hang | (done & any exit_code != 0)
state  out  2  RUN=0, DONE=1, TIMEOUT=2, HANG=3

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; every register is written on the rising edge of clk.
- Reset values: state=RUN; termination=0; exit_code=0; retired=0; done, timeout, hang and fail=0; cycle and idle counters=0.
- hit[i] = trace_valid[i] & ~termination[i] & (trace_insn[i]==TERM_INSN), evaluated in RUN only.
- Latency: termination[i] and exit_code[i] (taken from trace_r3[i] in the hit cycle) are registered. They are visible 1 cycle after the retirement.
- After termination[i] is set, trace_valid[i] is ignored: no count, no exit_code update, no second hit.
- retired[i] increments by 1 when trace_valid[i] & ~termination[i] in RUN. The terminating instruction is counted. The counter saturates at 2^CNT_W-1 and does not wrap.
- Completion: if (termination | hit) is all-ones, next state is DONE. done and the final termination bit rise on the same edge.
- Several cores may hit in the same cycle. All are captured, each with its own trace_r3.
- Cycle counter: increments every RUN cycle. If TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1 and completion does not occur in that cycle, next state is TIMEOUT. timeout is therefore high from cycle TIMEOUT_CYCLES after the first cycle with rst low.
- Idle counter: cleared when cpu_stall is high or any trace_valid[i] & ~termination[i]. Otherwise it increments, saturating. If STALL_LIMIT!=0 and the counter equals STALL_LIMIT-1 without a clear, next state is HANG.
- Priority of next state in the same cycle: DONE > TIMEOUT > HANG.
- DONE, TIMEOUT and HANG are terminal. All counters, termination bits and exit codes freeze until rst.
- rst asserted in any state, including mid-run, returns every register to its reset value on the next edge.
- fail is registered together with state. For DONE it uses the exit codes being captured, so it is valid in the same cycle done rises.

Test Plan:
- NUM_CORES=1: 10 plain instructions, then TERM_INSN with trace_r3=0 -> retired=11, termination=1, done=1 and fail=0 exactly 1 cycle after the terminating retire.
- NUM_CORES=4: cores 0 and 2 terminate in the same cycle with r3=0 and 5, cores 1 and 3 three cycles later with r3=0 -> done rises with the last bit; exit_code[2]=5; fail=1.
- Core 0 terminates, then retires TERM_INSN with r3=7 plus 3 more instructions -> exit_code[0] unchanged, retired[0] unchanged, state stays RUN while core 1 runs.
- TIMEOUT_CYCLES=100, core retires every cycle and never terminates -> timeout=1 and state=2 at cycle 100. Counters then freeze.
- STALL_LIMIT=16, no trace_valid and cpu_stall=0 -> hang=1 after 16 idle cycles. Repeat with cpu_stall pulsed every 10 cycles -> no hang.
- CNT_W=4, 20 retirements -> retired=15 (saturated). Then rst pulse mid-run -> all outputs 0, state=RUN.
